// File: rtl/score_bcd_keeper_if.sv
// Award handshake, control pulses and score/high-score display bus
// between the game logic and the BCD score keeper.
interface score_bcd_keeper_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    clear;
   logic                    add_valid;
   logic [7:0]              add_points;
   logic                    add_ready;
   logic                    hiscore_update;
   logic [4*NUM_DIGITS-1:0] score_digits;
   logic [4*NUM_DIGITS-1:0] hiscore_digits;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    saturated;

   modport master (
      output clear, add_valid, add_points, hiscore_update,
      input  add_ready, score_digits, hiscore_digits, blank, saturated
   );

   modport slave (
      input  clear, add_valid, add_points, hiscore_update,
      output add_ready, score_digits, hiscore_digits, blank, saturated
   );
endinterface

// File: rtl/score_bcd_keeper.sv
// Digit-serial BCD score accumulator with high score and leading-zero blanking.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for an award; add_ready high unless clear is asserted
// S_ADD  | adding one digit per cycle; commits on the last digit
module score_bcd_keeper #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   score_bcd_keeper_if.slave   bus
);
   localparam int                      IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [4*NUM_DIGITS-1:0] ALL_NINE = {NUM_DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    carry_q, carry_d;
   logic [7:0]              op_q, op_d;
   logic [4*NUM_DIGITS-1:0] work_q, work_d;
   logic [4*NUM_DIGITS-1:0] score_q, score_d;
   logic [4*NUM_DIGITS-1:0] hiscore_q;
   logic                    sat_q, sat_d;
   logic                    ready;
   logic [3:0]              cur_digit, op_digit, digit_res;
   logic [4:0]              sum, sum_adj;
   logic                    digit_carry;
   logic [NUM_DIGITS-1:0]   blank_c;
   logic                    all_zero;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   // Next-state, digit adder and commit logic; clear overrides everything
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      op_d        = op_q;
      work_d      = work_q;
      score_d     = score_q;
      sat_d       = sat_q;
      ready       = (state_q == S_IDLE) && !bus.clear;
      cur_digit   = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) cur_digit = work_q[4*i +: 4];
      end
      // only the two lowest digits receive operand digits
      op_digit    = (idx_q == IDX_W'(0)) ? op_q[3:0] :
                    (idx_q == IDX_W'(1)) ? op_q[7:4] : 4'd0;
      sum         = {1'b0, cur_digit} + {1'b0, op_digit} + {4'd0, carry_q};
      sum_adj     = sum - 5'd10;
      digit_carry = (sum > 5'd9);
      digit_res   = digit_carry ? sum_adj[3:0] : sum[3:0];

      case (state_q)
         S_IDLE: begin
            if (bus.add_valid && ready) begin
               op_d    = {clamp_bcd(bus.add_points[7:4]), clamp_bcd(bus.add_points[3:0])};
               work_d  = score_q;
               idx_d   = '0;
               carry_d = 1'b0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) work_d[4*i +: 4] = digit_res;
            end
            carry_d = digit_carry;
            if (idx_q == LAST_IDX) begin
               // carry out of the top digit means the score overflowed: pin at all nines
               score_d = digit_carry ? ALL_NINE : work_d;
               sat_d   = sat_q | digit_carry;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.clear) begin
         state_d = S_IDLE;
         score_d = '0;
         sat_d   = 1'b0;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= '0;
         work_q  <= '0;
         score_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_q    <= op_d;
         work_q  <= work_d;
         score_q <= score_d;
         sat_q   <= sat_d;
      end
   end

   // High-score capture from the pre-edge committed score; clear does not touch it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hiscore_q <= '0;
      end else if (bus.hiscore_update && (score_q > hiscore_q)) begin
         hiscore_q <= score_q;
      end
   end

   // Leading-zero blanking from the top digit down; the ones digit always shows
   always_comb begin
      blank_c  = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero   = all_zero && (score_q[4*i +: 4] == 4'd0);
         blank_c[i] = all_zero;
      end
   end

   assign bus.add_ready      = ready;
   assign bus.score_digits   = score_q;
   assign bus.hiscore_digits = hiscore_q;
   assign bus.blank          = blank_c;
   assign bus.saturated      = sat_q;
endmodule

// File: tb/tb_score_bcd_keeper.sv
// Testbench for score_bcd_keeper: integer reference model feeding a
// scoreboard queue of expected commits.
module tb_score_bcd_keeper;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   score_bcd_keeper_if #(.NUM_DIGITS(N)) bus ();
   score_bcd_keeper #(.NUM_DIGITS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_score;
   int          m_hi;
   logic        m_sat;
   logic [16:0] sb_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] b;
      int          t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         b[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return b;
   endfunction

   function automatic int pts2int(input logic [7:0] p);
      int hi, lo;
      hi = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
      lo = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
      return hi * 10 + lo;
   endfunction

   function automatic logic [3:0] blank_of(input int v);
      if (v < 10)        return 4'b1110;
      else if (v < 100)  return 4'b1100;
      else if (v < 1000) return 4'b1000;
      else               return 4'b0000;
   endfunction

   // Drive one award, holding valid until the commit; checks the busy window and commit
   task automatic do_award(input logic [7:0] pts);
      logic [15:0] old;
      logic [16:0] exp;
      int          w;
      @(negedge clk);
      bus.add_valid  = 1'b1;
      bus.add_points = pts;
      w = 0;
      while (!bus.add_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.add_ready) check_val("ready_timeout", 32'(bus.add_ready), 32'd1);
      old = int2bcd(m_score);
      m_score = m_score + pts2int(pts);
      if (m_score > 9999) begin
         m_score = 9999;
         m_sat   = 1'b1;
      end
      sb_q.push_back({m_sat, int2bcd(m_score)});
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         check_val("busy_ready", 32'(bus.add_ready), 32'd0);
         check_val("hold_score", 32'(bus.score_digits), 32'(old));
      end
      @(negedge clk);
      bus.add_valid = 1'b0;
      exp = sb_q.pop_front();
      check_val("commit_score", 32'(bus.score_digits), 32'(exp[15:0]));
      check_val("commit_sat", 32'(bus.saturated), 32'(exp[16]));
      check_val("ready_back", 32'(bus.add_ready), 32'd1);
      check_val("commit_blank", 32'(bus.blank), 32'(blank_of(m_score)));
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      m_score = 0;
      m_sat   = 1'b0;
      check_val("clear_score", 32'(bus.score_digits), 32'd0);
      check_val("clear_sat", 32'(bus.saturated), 32'd0);
      check_val("clear_hi_kept", 32'(bus.hiscore_digits), 32'(int2bcd(m_hi)));
   endtask

   task automatic do_hi_pulse();
      @(negedge clk);
      bus.hiscore_update = 1'b1;
      if (m_score > m_hi) m_hi = m_score;
      @(negedge clk);
      bus.hiscore_update = 1'b0;
      check_val("hiscore", 32'(bus.hiscore_digits), 32'(int2bcd(m_hi)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit expired, expected end of test");
      $fatal(1);
   end

   initial begin
      rst_n              = 1'b0;
      bus.clear          = 1'b0;
      bus.add_valid      = 1'b0;
      bus.add_points     = 8'h00;
      bus.hiscore_update = 1'b0;
      m_score = 0;
      m_hi    = 0;
      m_sat   = 1'b0;
      #1;
      check_val("rst_score", 32'(bus.score_digits), 32'd0);
      check_val("rst_hi", 32'(bus.hiscore_digits), 32'd0);
      check_val("rst_sat", 32'(bus.saturated), 32'd0);
      check_val("rst_ready", 32'(bus.add_ready), 32'd1);
      check_val("rst_blank", 32'(bus.blank), 32'(4'b1110));
      @(negedge clk);
      rst_n = 1'b1;

      // single award, latency and blanking
      do_award(8'h25);
      check_val("score_0025", 32'(bus.score_digits), 32'h0025);
      check_val("blank_0025", 32'(bus.blank), 32'(4'b1100));

      // carry ripple through all digits
      do_clear();
      repeat (10) do_award(8'h99);
      do_award(8'h09);
      check_val("score_0999", 32'(bus.score_digits), 32'h0999);
      do_award(8'h01);
      check_val("score_1000", 32'(bus.score_digits), 32'h1000);
      check_val("blank_1000", 32'(bus.blank), 32'(4'b0000));
      check_val("sat_1000", 32'(bus.saturated), 32'd0);
      repeat (N + 2) @(negedge clk);
      check_val("no_reaccept", 32'(bus.score_digits), 32'h1000);

      // saturation
      do_clear();
      repeat (100) do_award(8'h99);
      do_award(8'h90);
      check_val("score_9990", 32'(bus.score_digits), 32'h9990);
      do_award(8'h25);
      check_val("score_sat", 32'(bus.score_digits), 32'h9999);
      check_val("sat_set", 32'(bus.saturated), 32'd1);
      do_award(8'h01);
      check_val("sat_hold", 32'(bus.score_digits), 32'h9999);
      check_val("sat_sticky", 32'(bus.saturated), 32'd1);
      do_clear();

      // clear aborting an in-flight add
      do_award(8'h99);
      do_award(8'h01);
      check_val("score_0100", 32'(bus.score_digits), 32'h0100);
      @(negedge clk);
      bus.add_valid  = 1'b1;
      bus.add_points = 8'h50;
      @(posedge clk);
      @(negedge clk);
      bus.add_valid = 1'b0;
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      m_score = 0;
      #1;
      check_val("abort_score", 32'(bus.score_digits), 32'd0);
      check_val("abort_ready", 32'(bus.add_ready), 32'd1);
      repeat (N + 2) @(negedge clk);
      check_val("abort_no_commit", 32'(bus.score_digits), 32'd0);

      // clear together with valid: award refused
      @(negedge clk);
      bus.clear      = 1'b1;
      bus.add_valid  = 1'b1;
      bus.add_points = 8'h33;
      #1;
      check_val("clear_blocks_ready", 32'(bus.add_ready), 32'd0);
      @(negedge clk);
      bus.clear     = 1'b0;
      bus.add_valid = 1'b0;
      #1;
      check_val("clear_valid_idle", 32'(bus.add_ready), 32'd1);
      repeat (N + 2) @(negedge clk);
      check_val("clear_valid_score", 32'(bus.score_digits), 32'd0);

      // high score
      do_award(8'h99);
      do_award(8'h21);
      do_hi_pulse();
      check_val("hi_0120", 32'(bus.hiscore_digits), 32'h0120);
      do_award(8'h99);
      do_award(8'h99);
      do_award(8'h22);
      check_val("score_0340", 32'(bus.score_digits), 32'h0340);
      do_hi_pulse();
      check_val("hi_0340", 32'(bus.hiscore_digits), 32'h0340);
      do_clear();
      do_award(8'h10);
      do_hi_pulse();
      check_val("hi_kept", 32'(bus.hiscore_digits), 32'h0340);

      // illegal nibbles clamp to nine
      do_clear();
      do_award(8'hFA);
      check_val("score_clamp", 32'(bus.score_digits), 32'h0099);

      // asynchronous reset in the middle of an add
      @(negedge clk);
      bus.add_valid  = 1'b1;
      bus.add_points = 8'h01;
      @(posedge clk);
      @(negedge clk);
      bus.add_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      m_score = 0;
      m_hi    = 0;
      m_sat   = 1'b0;
      #1;
      check_val("arst_score", 32'(bus.score_digits), 32'd0);
      check_val("arst_hi", 32'(bus.hiscore_digits), 32'd0);
      check_val("arst_sat", 32'(bus.saturated), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("arst_ready", 32'(bus.add_ready), 32'd1);
      repeat (N + 2) @(negedge clk);
      check_val("arst_no_commit", 32'(bus.score_digits), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
